// File: rtl/nmed_sweep_engine.sv
// nmed_sweep_engine: sweeps all operand pairs into external multipliers and accumulates error-distance statistics.
module nmed_sweep_engine #(
    parameter int W        = 8,
    parameter int PIPE_LAT = 0,
    parameter int SIGNED   = 1
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_start,
    output logic           o_busy,
    output logic           o_done,
    output logic [W-1:0]   o_x,
    output logic [W-1:0]   o_y,
    input  logic [2*W-1:0] i_prod_approx,
    input  logic [2*W-1:0] i_prod_exact,
    output logic [4*W:0]   o_sum_ed,
    output logic [2*W:0]   o_max_ed,
    output logic [2*W:0]   o_max_exact,
    output logic [2*W:0]   o_err_count,
    output logic [2*W:0]   o_sample_count
);
    localparam int PW = 2 * W;
    localparam int SW = 4 * W + 1;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SWEEP = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] k_q, k_d;
    logic [SW-1:0] sum_q, sum_d;
    logic [PW:0]   max_ed_q, max_ed_d, max_ex_q, max_ex_d, err_q, err_d, smp_q, smp_d;
    logic [PW:0]   ext_a, ext_e, diff, ed, abs_e;
    logic          start_ok, sweeping, draining, valid;

    assign sweeping = state_q == S_SWEEP;
    assign draining = state_q == S_DRAIN;
    assign start_ok = i_start && (state_q == S_IDLE || state_q == S_DONE);

    // A tag entering with each swept pair marks when its products arrive.
    generate
        if (PIPE_LAT == 0) begin : g_comb
            assign valid = sweeping;
        end else begin : g_pipe
            logic [PIPE_LAT-1:0] tag_q;
            always_ff @(posedge i_clk) begin
                if (i_rst) tag_q <= '0;
                else       tag_q <= PIPE_LAT'({tag_q, sweeping});
            end
            assign valid = tag_q[PIPE_LAT-1];
        end
    endgenerate

    assign ext_a = SIGNED != 0 ? {i_prod_approx[PW-1], i_prod_approx} : {1'b0, i_prod_approx};
    assign ext_e = SIGNED != 0 ? {i_prod_exact[PW-1], i_prod_exact} : {1'b0, i_prod_exact};
    assign diff  = ext_a - ext_e;
    assign ed    = diff[PW] ? -diff : diff;
    assign abs_e = ext_e[PW] ? -ext_e : ext_e;

    always_comb begin
        state_d  = state_q;
        k_d      = (sweeping || draining) ? k_q + PW'(1) : k_q;
        sum_d    = sum_q;
        max_ed_d = max_ed_q;
        max_ex_d = max_ex_q;
        err_d    = err_q;
        smp_d    = smp_q;
        if (start_ok) begin
            state_d  = S_SWEEP;
            k_d      = '0;
            sum_d    = '0;
            max_ed_d = '0;
            max_ex_d = '0;
            err_d    = '0;
            smp_d    = '0;
        end else begin
            // k wraps to 0 on leaving SWEEP, so it doubles as the drain counter.
            if (sweeping && &k_q) state_d = PIPE_LAT > 0 ? S_DRAIN : S_DONE;
            else if (draining && k_q == PW'(PIPE_LAT - 1)) state_d = S_DONE;
            if (valid) begin
                sum_d    = sum_q + SW'(ed);
                max_ed_d = ed > max_ed_q ? ed : max_ed_q;
                max_ex_d = abs_e > max_ex_q ? abs_e : max_ex_q;
                err_d    = err_q + {{PW{1'b0}}, |ed};
                smp_d    = smp_q + (PW+1)'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            k_q      <= '0;
            sum_q    <= '0;
            max_ed_q <= '0;
            max_ex_q <= '0;
            err_q    <= '0;
            smp_q    <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            sum_q    <= sum_d;
            max_ed_q <= max_ed_d;
            max_ex_q <= max_ex_d;
            err_q    <= err_d;
            smp_q    <= smp_d;
        end
    end

    assign o_busy         = sweeping || draining;
    assign o_done         = state_q == S_DONE;
    assign o_x            = sweeping ? k_q[PW-1:W] : '0;
    assign o_y            = sweeping ? k_q[W-1:0] : '0;
    assign o_sum_ed       = sum_q;
    assign o_max_ed       = max_ed_q;
    assign o_max_exact    = max_ex_q;
    assign o_err_count    = err_q;
    assign o_sample_count = smp_q;
endmodule

// File: tb/tb_nmed_sweep_engine.sv
// tb_nmed_sweep_engine: directed checks of the sweep engine in three configurations.
module tb_nmed_sweep_engine;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // W=8, combinational, signed; approx wrong only at (5,7)
    logic        rst8, st8, busy8, done8;
    logic [7:0]  x8, y8;
    logic [15:0] pa8, pe8;
    logic [32:0] sum8;
    logic [16:0] med8, mex8, err8, smp8;

    // W=2, two-stage multipliers, unsigned; approx = exact + modep
    logic        rstp, stp, busyp, donep, modep;
    logic [1:0]  xp, yp;
    logic [3:0]  ep, p1a, p1e, p2a, p2e;
    logic [8:0]  sump;
    logic [4:0]  medp, mexp, errp, smpp;

    // W=2, combinational, signed; approx = exact + 3
    logic        rstc, stc, busyc, donec;
    logic [1:0]  xc, yc;
    logic [3:0]  pac, pec;
    logic [8:0]  sumc;
    logic [4:0]  medc, mexc, errc, smpc;

    always_comb begin
        pe8 = 16'($signed(x8) * $signed(y8));
        pa8 = (x8 == 8'd5 && y8 == 8'd7) ? pe8 - 16'd10 : pe8;
        ep  = 4'(xp * yp);
        pec = 4'($signed(xc) * $signed(yc));
        pac = pec + 4'd3;
    end

    always @(posedge clk) begin
        p1e <= ep;
        p1a <= ep + {3'b000, modep};
        p2e <= p1e;
        p2a <= p1a;
    end

    nmed_sweep_engine #(.W(8), .PIPE_LAT(0), .SIGNED(1)) u8 (
        .i_clk(clk), .i_rst(rst8), .i_start(st8), .o_busy(busy8), .o_done(done8),
        .o_x(x8), .o_y(y8), .i_prod_approx(pa8), .i_prod_exact(pe8),
        .o_sum_ed(sum8), .o_max_ed(med8), .o_max_exact(mex8), .o_err_count(err8),
        .o_sample_count(smp8));

    nmed_sweep_engine #(.W(2), .PIPE_LAT(2), .SIGNED(0)) up (
        .i_clk(clk), .i_rst(rstp), .i_start(stp), .o_busy(busyp), .o_done(donep),
        .o_x(xp), .o_y(yp), .i_prod_approx(p2a), .i_prod_exact(p2e),
        .o_sum_ed(sump), .o_max_ed(medp), .o_max_exact(mexp), .o_err_count(errp),
        .o_sample_count(smpp));

    nmed_sweep_engine #(.W(2), .PIPE_LAT(0), .SIGNED(1)) uc (
        .i_clk(clk), .i_rst(rstc), .i_start(stc), .o_busy(busyc), .o_done(donec),
        .o_x(xc), .o_y(yc), .i_prod_approx(pac), .i_prod_exact(pec),
        .o_sum_ed(sumc), .o_max_ed(medc), .o_max_exact(mexc), .o_err_count(errc),
        .o_sample_count(smpc));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic pulse(input int sel);
        @(posedge clk); #1;
        if (sel == 0) st8 = 1'b1; else if (sel == 1) stp = 1'b1; else stc = 1'b1;
        @(posedge clk); #1;
        st8 = 1'b0; stp = 1'b0; stc = 1'b0;
    endtask

    // n counts cycles from the one in which start was sampled.
    task automatic wait_done(input int sel, input int lim, input int n0, output int n);
        n = n0;
        while (!((sel == 0 && done8) || (sel == 1 && donep) || (sel == 2 && donec)) && n <= lim) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    int n;

    initial begin
        rst8 = 1'b1; rstp = 1'b1; rstc = 1'b1;
        st8 = 1'b0; stp = 1'b0; stc = 1'b0; modep = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        chk("rst_x", x8, 0);
        chk("rst_sum", sum8, 0);
        chk("rst_smp", smpp, 0);
        rst8 = 1'b0; rstp = 1'b0; rstc = 1'b0;

        pulse(1);
        chk("p_busy_start", busyp, 1);
        wait_done(1, 40, 1, n);
        chk("p_lat", n, 19);
        chk("p_busy_end", busyp, 0);
        chk("p_smp", smpp, 16);
        chk("p_sum", sump, 16);
        chk("p_maxed", medp, 1);
        chk("p_maxex", mexp, 9);
        chk("p_err", errp, 16);

        modep = 1'b0;
        pulse(1);
        chk("p2_done_clr", donep, 0);
        chk("p2_sum_clr", sump, 0);
        chk("p2_smp_clr", smpp, 0);
        wait_done(1, 40, 1, n);
        chk("p2_lat", n, 19);
        chk("p2_sum", sump, 0);
        chk("p2_err", errp, 0);
        chk("p2_maxed", medp, 0);
        chk("p2_maxex", mexp, 9);
        chk("p2_smp", smpp, 16);

        pulse(2);
        chk("c_x0", xc, 0);
        chk("c_y0", yc, 0);
        repeat (4) @(posedge clk);
        #1 stc = 1'b1;
        @(posedge clk);
        #1 stc = 1'b0;
        wait_done(2, 40, 6, n);
        chk("c_lat", n, 17);
        chk("c_sum", sumc, 48);
        chk("c_maxed", medc, 3);
        chk("c_err", errc, 16);
        chk("c_smp", smpc, 16);
        chk("c_maxex", mexc, 4);

        pulse(2);
        repeat (6) @(posedge clk);
        #1;
        chk("c_x6", xc, 1);
        chk("c_y6", yc, 2);
        rstc = 1'b1;
        @(posedge clk);
        #1 rstc = 1'b0;
        chk("cr_busy", busyc, 0);
        chk("cr_done", donec, 0);
        chk("cr_x", xc, 0);
        chk("cr_y", yc, 0);
        chk("cr_sum", sumc, 0);
        chk("cr_smp", smpc, 0);
        chk("cr_err", errc, 0);
        chk("cr_maxed", medc, 0);
        chk("cr_maxex", mexc, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("cr_idle", busyc, 0);

        pulse(2);
        wait_done(2, 40, 1, n);
        chk("c3_lat", n, 17);
        chk("c3_sum", sumc, 48);
        chk("c3_smp", smpc, 16);

        rstc = 1'b1; stc = 1'b1;
        @(posedge clk);
        #1 rstc = 1'b0; stc = 1'b0;
        chk("rs_busy", busyc, 0);
        chk("rs_done", donec, 0);
        chk("rs_smp", smpc, 0);

        pulse(0);
        chk("w8_busy", busy8, 1);
        wait_done(0, 70000, 1, n);
        chk("w8_lat", n, 65537);
        chk("w8_sum", sum8, 10);
        chk("w8_maxed", med8, 10);
        chk("w8_err", err8, 1);
        chk("w8_maxex", mex8, 16384);
        chk("w8_smp", smp8, 65536);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
